video_timing_gen: RTL and testbench

- Video source for the pipeline: generates programmable vsync/hsync/de timing plus a selectable RGB test pattern.
- Directly drives the video input of the line-buffer controller, which is the sink of this protocol.
- Timing fields and the pattern are latched per frame, so reconfiguration only takes effect at frame boundaries.
- All video outputs are registered.

---
 rtl/video_timing_gen_if.sv | 20 ++
 rtl/video_timing_gen.sv | 201 ++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - video stream from the timing generator to the line-buffer controller
interface video_timing_gen_if #(
   parameter int DW = 10
);
   logic          o_vsync;
   logic          o_hsync;
   logic          o_de;
   logic          o_frame_start;
   logic [DW-1:0] o_red;
   logic [DW-1:0] o_green;
   logic [DW-1:0] o_blue;

   modport master (
      output o_vsync, o_hsync, o_de, o_frame_start, o_red, o_green, o_blue
   );

   modport slave (
      input  o_vsync, o_hsync, o_de, o_frame_start, o_red, o_green, o_blue
   );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - programmable vsync/hsync/de timing with RGB test patterns
module video_timing_gen #(
   parameter int TW = 6,
   parameter int DW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_en,
   input  logic [TW-1:0] i_vsw,
   input  logic [TW-1:0] i_vbp,
   input  logic [TW-1:0] i_vact,
   input  logic [TW-1:0] i_vfp,
   input  logic [TW-1:0] i_hsw,
   input  logic [TW-1:0] i_hbp,
   input  logic [TW-1:0] i_hact,
   input  logic [TW-1:0] i_hfp,
   input  logic [1:0]    i_pattern,
   video_timing_gen_if.master vid,
   output logic          o_busy,
   output logic          o_cfg_err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        r_state;
   logic [TW-1:0] r_vsw, r_vbp, r_vact, r_vfp;
   logic [TW-1:0] r_hsw, r_hbp, r_hact, r_hfp;
   logic [1:0]    r_pat;
   logic [7:0]    r_h_cnt, r_v_cnt;
   logic [9:0]    r_frame_cnt;
   logic          r_cfg_err;
   logic          r_vsync, r_hsync, r_de, r_frame_start;
   logic [DW-1:0] r_red, r_green, r_blue;

   logic          w_cfg_ok;
   logic [7:0]    w_htot, w_vtot;
   logic          w_h_last, w_v_last;
   logic          w_start, w_reload, w_load;
   logic [7:0]    w_hact_lo, w_hact_hi, w_vact_lo, w_vact_hi;
   logic          w_de;
   logic [TW-1:0] w_x, w_y;
   logic [DW-1:0] w_r, w_g, w_b;

   // Live (unlatched) config check: syncs and active regions must be nonzero
   assign w_cfg_ok = (i_hsw != '0) && (i_hact != '0) && (i_vsw != '0) && (i_vact != '0);

   // Totals and region bounds always come from the per-frame latched copy
   assign w_htot    = 8'(r_hsw) + 8'(r_hbp) + 8'(r_hact) + 8'(r_hfp);
   assign w_vtot    = 8'(r_vsw) + 8'(r_vbp) + 8'(r_vact) + 8'(r_vfp);
   assign w_h_last  = (r_h_cnt == w_htot - 8'd1);
   assign w_v_last  = (r_v_cnt == w_vtot - 8'd1);
   assign w_hact_lo = 8'(r_hsw) + 8'(r_hbp);
   assign w_hact_hi = w_hact_lo + 8'(r_hact);
   assign w_vact_lo = 8'(r_vsw) + 8'(r_vbp);
   assign w_vact_hi = w_vact_lo + 8'(r_vact);

   assign w_start  = (r_state == IDLE) && i_en && w_cfg_ok;
   assign w_reload = (r_state == RUN) && w_h_last && w_v_last && i_en && w_cfg_ok;
   assign w_load   = w_start || w_reload;

   assign w_de = (r_v_cnt >= w_vact_lo) && (r_v_cnt < w_vact_hi) &&
                 (r_h_cnt >= w_hact_lo) && (r_h_cnt < w_hact_hi);
   assign w_x  = TW'(r_h_cnt - w_hact_lo);
   assign w_y  = TW'(r_v_cnt - w_vact_lo);

   // Pattern decode of the active coordinate; black outside the active window
   always_comb begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
      if (w_de) begin
         case (r_pat)
            2'd0: begin
               w_r = DW'({w_x, 4'b0000});
               w_g = w_r;
               w_b = w_r;
            end
            2'd1: begin
               w_r = DW'({w_y, 4'b0000});
               w_g = w_r;
               w_b = w_r;
            end
            2'd2: begin
               w_r = {DW{w_x[0] ^ w_y[0]}};
               w_g = w_r;
               w_b = w_r;
            end
            default: begin
               w_r = DW'(r_frame_cnt);
               w_g = DW'(w_y);
               w_b = DW'(w_x);
            end
         endcase
      end
   end

   // Latch timing fields and pattern at frame boundaries only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsw  <= '0;
         r_vbp  <= '0;
         r_vact <= '0;
         r_vfp  <= '0;
         r_hsw  <= '0;
         r_hbp  <= '0;
         r_hact <= '0;
         r_hfp  <= '0;
         r_pat  <= '0;
      end else if (w_load) begin
         r_vsw  <= i_vsw;
         r_vbp  <= i_vbp;
         r_vact <= i_vact;
         r_vfp  <= i_vfp;
         r_hsw  <= i_hsw;
         r_hbp  <= i_hbp;
         r_hact <= i_hact;
         r_hfp  <= i_hfp;
         r_pat  <= i_pattern;
      end
   end

   // Run/idle FSM with counters and registered video outputs (one cycle behind the counters)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_frame_cnt   <= '0;
         r_cfg_err     <= 1'b0;
         r_vsync       <= 1'b0;
         r_hsync       <= 1'b0;
         r_de          <= 1'b0;
         r_frame_start <= 1'b0;
         r_red         <= '0;
         r_green       <= '0;
         r_blue        <= '0;
      end else begin
         if (r_state == RUN) begin
            r_vsync       <= (r_v_cnt < 8'(r_vsw));
            r_hsync       <= (r_h_cnt < 8'(r_hsw));
            r_de          <= w_de;
            r_frame_start <= (r_h_cnt == 8'd0) && (r_v_cnt == 8'd0);
            r_red         <= w_r;
            r_green       <= w_g;
            r_blue        <= w_b;
         end else begin
            r_vsync       <= 1'b0;
            r_hsync       <= 1'b0;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
         end

         case (r_state)
            IDLE: begin
               if (i_en) begin
                  if (w_cfg_ok) begin
                     r_state   <= RUN;
                     r_h_cnt   <= '0;
                     r_v_cnt   <= '0;
                     r_cfg_err <= 1'b0;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
            end
            default: begin
               if (w_h_last) begin
                  r_h_cnt <= '0;
                  if (w_v_last) begin
                     r_v_cnt <= '0;
                     if (w_reload) begin
                        r_frame_cnt <= r_frame_cnt + 10'd1;
                     end else begin
                        r_state <= IDLE;
                        if (i_en) r_cfg_err <= 1'b1;
                     end
                  end else begin
                     r_v_cnt <= r_v_cnt + 8'd1;
                  end
               end else begin
                  r_h_cnt <= r_h_cnt + 8'd1;
               end
            end
         endcase
      end
   end

   assign vid.o_vsync       = r_vsync;
   assign vid.o_hsync       = r_hsync;
   assign vid.o_de          = r_de;
   assign vid.o_frame_start = r_frame_start;
   assign vid.o_red         = r_red;
   assign vid.o_green       = r_green;
   assign vid.o_blue        = r_blue;
   assign o_busy            = (r_state == RUN);
   assign o_cfg_err         = r_cfg_err;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen
module tb_video_timing_gen;
   localparam int TW = 6;
   localparam int DW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_en;
   logic [TW-1:0] i_vsw, i_vbp, i_vact, i_vfp, i_hsw, i_hbp, i_hact, i_hfp;
   logic [1:0]    i_pattern;
   logic          o_busy, o_cfg_err;

   video_timing_gen_if #(.DW(DW)) vif ();

   video_timing_gen #(.TW(TW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (i_en),
      .i_vsw     (i_vsw),
      .i_vbp     (i_vbp),
      .i_vact    (i_vact),
      .i_vfp     (i_vfp),
      .i_hsw     (i_hsw),
      .i_hbp     (i_hbp),
      .i_hact    (i_hact),
      .i_hfp     (i_hfp),
      .i_pattern (i_pattern),
      .vid       (vif),
      .o_busy    (o_busy),
      .o_cfg_err (o_cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          vs;
      logic          hs;
      logic          de;
      logic          fs;
      logic [DW-1:0] r;
      logic [DW-1:0] g;
      logic [DW-1:0] b;
   } pix_t;

   pix_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   int   vsw = 1, vbp = 1, vact = 4, vfp = 1;
   int   hsw = 1, hbp = 1, hact = 4, hfp = 1;

   int   st_cyc, st_de, st_fs, st_hs, st_vs, st_vs_head, st_first_de, st_ones;
   pix_t st_first_pix;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic pix_t dut_pix();
      return {vif.o_vsync, vif.o_hsync, vif.o_de, vif.o_frame_start,
              vif.o_red, vif.o_green, vif.o_blue};
   endfunction

   task automatic drive();
      i_vsw  = TW'(vsw);
      i_vbp  = TW'(vbp);
      i_vact = TW'(vact);
      i_vfp  = TW'(vfp);
      i_hsw  = TW'(hsw);
      i_hbp  = TW'(hbp);
      i_hact = TW'(hact);
      i_hfp  = TW'(hfp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      st_cyc = 0; st_de = 0; st_fs = 0; st_hs = 0; st_vs = 0;
      st_vs_head = 0; st_first_de = -1; st_ones = 0; st_first_pix = '0;
   endtask

   // Expected frame built line by line from the current config, as the sink would see it
   task automatic push_frame(input int pat, input int fc);
      int vt = vsw + vbp + vact + vfp;
      int ht = hsw + hbp + hact + hfp;
      for (int v = 0; v < vt; v++) begin
         for (int h = 0; h < ht; h++) begin
            pix_t       p;
            logic [5:0] x, y;
            p    = '0;
            p.vs = (v < vsw);
            p.hs = (h < hsw);
            p.fs = (v == 0) && (h == 0);
            p.de = (v >= vsw + vbp) && (v < vsw + vbp + vact) &&
                   (h >= hsw + hbp) && (h < hsw + hbp + hact);
            x    = 6'(h - hsw - hbp);
            y    = 6'(v - vsw - vbp);
            if (p.de) begin
               case (pat)
                  0: begin p.r = {x, 4'b0000}; p.g = p.r; p.b = p.r; end
                  1: begin p.r = {y, 4'b0000}; p.g = p.r; p.b = p.r; end
                  2: begin p.r = (x[0] ^ y[0]) ? 10'd1023 : 10'd0; p.g = p.r; p.b = p.r; end
                  default: begin p.r = 10'(fc % 1024); p.g = {4'b0000, y}; p.b = {4'b0000, x}; end
               endcase
            end
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back('0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         pix_t o, e;
         step();
         o = dut_pix();
         n_vec++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h expected none", o);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pix", o, e);
         end
         if (o.de) begin
            if (st_first_de < 0) begin
               st_first_de  = st_cyc;
               st_first_pix = o;
            end
            st_de++;
            if (o.r == {DW{1'b1}}) st_ones++;
         end
         if (o.fs) st_fs++;
         if (o.hs) st_hs++;
         if (o.vs) st_vs++;
         if (o.vs && st_cyc < 7) st_vs_head++;
         st_cyc++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      i_en  = 1'b0;
      i_pattern = 2'd3;
      drive();

      // Reset state
      repeat (3) step();
      check("rst_pix", dut_pix(), 0);
      check("rst_busy", o_busy, 0);
      check("rst_cfg_err", o_cfg_err, 0);
      rst_n = 1'b1;
      step();
      check("idle_pix", dut_pix(), 0);
      check("idle_busy", o_busy, 0);

      // Base timing, pattern 3
      i_en = 1'b1;
      step();
      check("start_busy", o_busy, 1);
      check("start_pix", dut_pix(), 0);
      push_frame(3, 0);
      push_frame(3, 1);
      clr();
      run(49);
      check("f0_de", st_de, 16);
      check("f0_fs", st_fs, 1);
      check("f0_hs", st_hs, 7);
      check("f0_vs", st_vs, 7);
      check("f0_vs_head", st_vs_head, 7);
      check("f0_first_de", st_first_de, 16);
      check("f0_first_rgb", {st_first_pix.r, st_first_pix.g, st_first_pix.b}, 0);
      clr();
      run(49);
      check("f1_de", st_de, 16);
      check("f1_first_r", st_first_pix.r, 1);

      // Mid-frame reconfiguration
      push_frame(3, 2);
      clr();
      run(10);
      hact = 2;
      drive();
      push_frame(3, 3);
      run(39);
      check("f2_de", st_de, 16);
      hact = 4;
      drive();
      push_frame(3, 4);
      clr();
      run(35);
      check("f3_de", st_de, 8);
      check("f3_fs", st_fs, 1);

      // Stop at clock 10
      clr();
      run(10);
      i_en = 1'b0;
      run(39);
      check("stop_de", st_de, 16);
      check("stop_busy", o_busy, 0);
      push_idle(20);
      clr();
      run(20);
      check("stop_no_fs", st_fs, 0);

      // Invalid config
      hact = 0;
      drive();
      i_en = 1'b1;
      push_idle(5);
      run(5);
      check("bad_cfg_err", o_cfg_err, 1);
      check("bad_busy", o_busy, 0);
      hact = 4;
      i_pattern = 2'd2;
      drive();
      push_idle(1);
      run(1);
      check("fix_busy", o_busy, 1);
      check("fix_cfg_err", o_cfg_err, 0);

      // Checkerboard
      push_frame(2, 4);
      push_frame(2, 5);
      clr();
      run(49);
      check("chk_de", st_de, 16);
      check("chk_ones", st_ones, 8);
      check("chk_first", st_first_pix.r, 0);

      // Reset mid-frame at clock 20
      run(20);
      rst_n = 1'b0;
      #1;
      check("mrst_pix", dut_pix(), 0);
      check("mrst_busy", o_busy, 0);
      exp_q.delete();
      i_pattern = 2'd3;
      step();
      step();
      rst_n = 1'b1;
      push_idle(1);
      run(1);
      check("rst_restart_busy", o_busy, 1);
      push_frame(3, 0);
      clr();
      run(49);
      check("rst_f_de", st_de, 16);
      check("rst_f_fs", st_fs, 1);
      check("rst_f_r", st_first_pix.r, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
